// File: rtl/universal_shift_reg_seq_if.sv
// rtl/universal_shift_reg_seq_if.sv - command/data bundle for the universal shift register
// Purpose: groups the controller-to-register command signals and the register outputs.
// Optional feature macro: USR_PARITY_EN (adds the registered parity output).
// Signals:
//   load, shift_left, shift_right, rotate, arith, ser_in_l, ser_in_r, data_in, start, count
//     : driven by the controller (master), consumed by the register (slave)
//   data_out, ser_out, busy, done [, parity]
//     : driven by the register (slave), observed by the controller (master)
interface universal_shift_reg_seq_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);
  logic             load;
  logic             shift_left;
  logic             shift_right;
  logic             rotate;
  logic             arith;
  logic             ser_in_l;
  logic             ser_in_r;
  logic [WIDTH-1:0] data_in;
  logic             start;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] data_out;
  logic             ser_out;
  logic             busy;
  logic             done;
`ifdef USR_PARITY_EN
  logic             parity;
`endif

  modport master (
    output load, shift_left, shift_right, rotate, arith, ser_in_l, ser_in_r,
    output data_in, start, count,
`ifdef USR_PARITY_EN
    input  parity,
`endif
    input  data_out, ser_out, busy, done
  );

  modport slave (
    input  load, shift_left, shift_right, rotate, arith, ser_in_l, ser_in_r,
    input  data_in, start, count,
`ifdef USR_PARITY_EN
    output parity,
`endif
    output data_out, ser_out, busy, done
  );
endinterface

// File: rtl/universal_shift_reg_seq.sv
// rtl/universal_shift_reg_seq.sv - WIDTH-bit universal shift/rotate register with multi-step ops
// Purpose: parallel load, single-step shift/rotate left/right (logical, arithmetic right),
//          and a start/busy/done multi-step shift of up to 2**CNT_W-1 steps.
// Optional feature macro: USR_PARITY_EN (registered XOR-reduction of data_out).
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : universal_shift_reg_seq_if.slave (commands in, data_out/ser_out/busy/done out)
module universal_shift_reg_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  universal_shift_reg_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             ser_q, ser_d;
  logic             dir_left_q, dir_left_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;

  // One-step results, using live rotate/arith/serial inputs.
  logic             left_in, right_in;
  logic [WIDTH-1:0] left_val, right_val;

  assign left_in   = bus.rotate ? data_q[WIDTH-1] : bus.ser_in_l;
  assign right_in  = bus.rotate ? data_q[0] : (bus.arith ? data_q[WIDTH-1] : bus.ser_in_r);
  assign left_val  = {data_q[WIDTH-2:0], left_in};
  assign right_val = {right_in, data_q[WIDTH-1:1]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      data_q      <= '0;
      ser_q       <= 1'b0;
      dir_left_q  <= 1'b0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      ser_q       <= ser_d;
      dir_left_q  <= dir_left_d;
      remaining_q <= remaining_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    ser_d       = ser_q;
    dir_left_d  = dir_left_q;
    remaining_d = remaining_q;

    case (state_q)
      RUN: begin
        if (bus.load) begin
          // Abort: take the load, drop back to IDLE without a done pulse.
          data_d      = bus.data_in;
          remaining_d = '0;
          state_d     = IDLE;
        end else begin
          if (dir_left_q) begin
            data_d = left_val;
            ser_d  = data_q[WIDTH-1];
          end else begin
            data_d = right_val;
            ser_d  = data_q[0];
          end
          remaining_d = remaining_q - CNT_W'(1);
          if (remaining_q == CNT_W'(1)) begin
            state_d = DONE;
          end
        end
      end

      default: begin
        // IDLE and DONE accept commands identically; DONE falls back to IDLE.
        state_d = IDLE;
        if (bus.load) begin
          data_d = bus.data_in;
        end else if (bus.start && (bus.shift_left || bus.shift_right)) begin
          dir_left_d = bus.shift_left;
          if (bus.count == '0) begin
            state_d = DONE;
          end else begin
            // The first step happens on the accepting edge.
            if (bus.shift_left) begin
              data_d = left_val;
              ser_d  = data_q[WIDTH-1];
            end else begin
              data_d = right_val;
              ser_d  = data_q[0];
            end
            remaining_d = bus.count - CNT_W'(1);
            state_d     = (bus.count == CNT_W'(1)) ? DONE : RUN;
          end
        end else if (bus.start) begin
          // start without a direction is ignored: hold.
        end else if (bus.shift_left) begin
          data_d = left_val;
          ser_d  = data_q[WIDTH-1];
        end else if (bus.shift_right) begin
          data_d = right_val;
          ser_d  = data_q[0];
        end
      end
    endcase
  end

  assign bus.data_out = data_q;
  assign bus.ser_out  = ser_q;
  assign bus.busy     = (state_q == RUN);
  assign bus.done     = (state_q == DONE);

`ifdef USR_PARITY_EN
  logic parity_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= ^data_d;
    end
  end

  assign bus.parity = parity_q;
`endif

endmodule

// File: tb/tb_universal_shift_reg_seq.sv
// tb/tb_universal_shift_reg_seq.sv - self-checking bench for universal_shift_reg_seq
module tb_universal_shift_reg_seq;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  universal_shift_reg_seq_if #(.WIDTH(8), .CNT_W(4)) bus ();

  universal_shift_reg_seq #(.WIDTH(8), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       ld, sl, sr, st, rot, ar, sil, sir;
    logic [7:0] din;
    logic [3:0] cnt;
    logic [7:0] e_data;
    logic       e_ser, e_busy, e_done;
  } vec_t;

  vec_t vecs [24];

  function automatic vec_t mk(input logic ld, sl, sr, st, rot, ar, sil, sir,
                              input logic [7:0] din, input logic [3:0] cnt,
                              input logic [7:0] e_data,
                              input logic e_ser, e_busy, e_done);
    vec_t v;
    v.ld = ld; v.sl = sl; v.sr = sr; v.st = st; v.rot = rot; v.ar = ar;
    v.sil = sil; v.sir = sir; v.din = din; v.cnt = cnt;
    v.e_data = e_data; v.e_ser = e_ser; v.e_busy = e_busy; v.e_done = e_done;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ld, sl, sr, st, rot, ar, sil, sir,
                       input logic [7:0] din, input logic [3:0] cnt);
    @(negedge clk);
    bus.load = ld; bus.shift_left = sl; bus.shift_right = sr; bus.start = st;
    bus.rotate = rot; bus.arith = ar; bus.ser_in_l = sil; bus.ser_in_r = sir;
    bus.data_in = din; bus.count = cnt;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [7:0] d, input logic s, b, dn);
    chk({tag, ".data"}, 32'(bus.data_out), 32'(d));
    chk({tag, ".ser"},  32'(bus.ser_out),  32'(s));
    chk({tag, ".busy"}, 32'(bus.busy),     32'(b));
    chk({tag, ".done"}, 32'(bus.done),     32'(dn));
  endtask

  initial begin
    total = 0;
    bad   = 0;

    //      ld sl sr st rt ar il ir  din    cnt   data   ser busy done
    vecs[0]  = mk(1,0,0,0,0,0,0,0, 8'hB5, 4'd0, 8'hB5, 0,0,0);
    vecs[1]  = mk(1,1,0,0,0,0,0,0, 8'h3C, 4'd0, 8'h3C, 0,0,0);
    vecs[2]  = mk(1,0,0,0,0,0,0,0, 8'hB5, 4'd0, 8'hB5, 0,0,0);
    vecs[3]  = mk(0,1,0,0,0,0,1,0, 8'h00, 4'd0, 8'h6B, 1,0,0);
    vecs[4]  = mk(1,0,0,0,0,0,0,0, 8'hB5, 4'd0, 8'hB5, 1,0,0);
    vecs[5]  = mk(0,0,1,0,0,0,0,0, 8'h00, 4'd0, 8'h5A, 1,0,0);
    vecs[6]  = mk(1,0,0,0,0,0,0,0, 8'hB5, 4'd0, 8'hB5, 1,0,0);
    vecs[7]  = mk(0,0,1,0,0,1,0,0, 8'h00, 4'd0, 8'hDA, 1,0,0);
    vecs[8]  = mk(0,0,1,0,1,0,0,0, 8'h00, 4'd0, 8'h6D, 0,0,0);
    vecs[9]  = mk(0,1,0,0,1,0,0,0, 8'h00, 4'd0, 8'hDA, 0,0,0);
    vecs[10] = mk(0,0,0,1,0,0,0,0, 8'h00, 4'd3, 8'hDA, 0,0,0);
    vecs[11] = mk(0,0,1,0,0,0,0,1, 8'h00, 4'd0, 8'hED, 0,0,0);
    vecs[12] = mk(1,0,0,0,0,0,0,0, 8'h81, 4'd0, 8'h81, 0,0,0);
    vecs[13] = mk(0,1,0,1,1,0,0,0, 8'h00, 4'd3, 8'h03, 1,1,0);
    vecs[14] = mk(0,0,0,0,1,0,0,0, 8'h00, 4'd0, 8'h06, 0,1,0);
    vecs[15] = mk(0,0,0,0,1,0,0,0, 8'h00, 4'd0, 8'h0C, 0,0,1);
    vecs[16] = mk(0,0,0,0,0,0,0,0, 8'h00, 4'd0, 8'h0C, 0,0,0);
    vecs[17] = mk(0,0,1,1,0,0,0,0, 8'h00, 4'd0, 8'h0C, 0,0,1);
    vecs[18] = mk(0,0,0,0,0,0,0,0, 8'h00, 4'd0, 8'h0C, 0,0,0);
    vecs[19] = mk(0,0,1,1,0,0,0,1, 8'h00, 4'd1, 8'h86, 0,0,1);
    vecs[20] = mk(0,1,0,0,0,0,0,0, 8'h00, 4'd0, 8'h0C, 1,0,0);
    vecs[21] = mk(1,0,0,0,0,0,0,0, 8'h80, 4'd0, 8'h80, 1,0,0);
    vecs[22] = mk(0,0,1,1,0,1,0,0, 8'h00, 4'd2, 8'hC0, 0,1,0);
    vecs[23] = mk(0,1,0,0,0,0,0,0, 8'h00, 4'd0, 8'h60, 0,0,1);

    // Reset with a pending load must still leave everything cleared.
    reset = 1'b1;
    bus.load = 1'b1; bus.shift_left = 1'b0; bus.shift_right = 1'b0; bus.start = 1'b0;
    bus.rotate = 1'b0; bus.arith = 1'b0; bus.ser_in_l = 1'b0; bus.ser_in_r = 1'b0;
    bus.data_in = 8'hB5; bus.count = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    bus.load = 1'b0;

    for (int i = 0; i < 24; i++) begin
      drive(vecs[i].ld, vecs[i].sl, vecs[i].sr, vecs[i].st, vecs[i].rot, vecs[i].ar,
            vecs[i].sil, vecs[i].sir, vecs[i].din, vecs[i].cnt);
      chk_all($sformatf("vec%0d", i), vecs[i].e_data, vecs[i].e_ser,
              vecs[i].e_busy, vecs[i].e_done);
`ifdef USR_PARITY_EN
      chk($sformatf("vec%0d.parity", i), 32'(bus.parity), 32'(^vecs[i].e_data));
`endif
    end

    // Abort a running op with load: no done pulse afterwards.
    drive(1,0,0,0,0,0,0,0, 8'h01, 4'd0);
    chk_all("abort.load", 8'h01, 1'b0, 1'b0, 1'b0);
    drive(0,1,0,1,0,0,0,0, 8'h00, 4'd5);
    chk_all("abort.s1", 8'h02, 1'b0, 1'b1, 1'b0);
    drive(0,0,0,0,0,0,0,0, 8'h00, 4'd0);
    chk_all("abort.s2", 8'h04, 1'b0, 1'b1, 1'b0);
    drive(1,0,0,0,0,0,0,0, 8'hA5, 4'd0);
    chk_all("abort.hit", 8'hA5, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive(0,0,0,0,0,0,0,0, 8'h00, 4'd0);
      chk_all($sformatf("abort.after%0d", i), 8'hA5, 1'b0, 1'b0, 1'b0);
    end

    // Asynchronous reset in the middle of RUN.
    drive(1,0,0,0,0,0,0,0, 8'h01, 4'd0);
    drive(0,1,0,1,0,0,0,0, 8'h00, 4'd5);
    chk_all("rst.s1", 8'h02, 1'b0, 1'b1, 1'b0);
    drive(0,0,0,0,0,0,0,0, 8'h00, 4'd0);
    chk_all("rst.s2", 8'h04, 1'b0, 1'b1, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk_all("rst.async", 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    drive(0,0,0,0,0,0,0,0, 8'h00, 4'd0);
    chk_all("rst.after", 8'h00, 1'b0, 1'b0, 1'b0);

`ifdef USR_PARITY_EN
    drive(1,0,0,0,0,0,0,0, 8'h07, 4'd0);
    chk("par.07", 32'(bus.parity), 32'd1);
    drive(0,1,0,0,0,0,0,0, 8'h00, 4'd0);
    chk("par.0E.data", 32'(bus.data_out), 32'h0E);
    chk("par.0E", 32'(bus.parity), 32'd1);
    drive(1,0,0,0,0,0,0,0, 8'h03, 4'd0);
    chk("par.03", 32'(bus.parity), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/universal_shift_reg_seq.md
Name: universal_shift_reg_seq

Overview:
Parametrised next-generation universal register.
- Widens the 4-bit load/shift-left/shift-right register to WIDTH bits.
- Adds rotate and arithmetic-right modes and separate serial inputs per direction.
- Adds a multi-cycle "shift by N" operation with a start/busy/done handshake.
- Sits in datapath blocks as a general staging/serialising register driven by a local controller.

Parameters:
WIDTH, 8, register width in bits (>= 2)
CNT_W, 4, width of the step-count input; one multi-step op performs up to 2**CNT_W-1 steps

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
load  input  1  parallel load of data_in
shift_left  input  1  shift/rotate one step toward MSB
shift_right  input  1  shift/rotate one step toward LSB
rotate  input  1  1: shifts are rotates (serial inputs ignored)
arith  input  1  1: non-rotate right shift replicates MSB instead of using ser_in_r
ser_in_l  input  1  bit entering LSB on a non-rotate left shift
ser_in_r  input  1  bit entering MSB on a logical right shift
data_in  input  WIDTH  parallel load data
start  input  1  begin a multi-step op; direction from shift_left/shift_right, step count from count
count  input  CNT_W  number of steps for the multi-step op
data_out  output  WIDTH  register contents (registered)
ser_out  output  1  last bit shifted or rotated out (registered)
busy  output  1  multi-step op in progress
done  output  1  one-cycle pulse when a multi-step op completes

Behaviour:
- Reset (asynchronous, any time, including mid-op):
  - data_out=0, ser_out=0, busy=0, done=0, FSM=IDLE, internal step counter=0.
- Step definition, applied on one clk edge:
  - Left: data_out <= {data_out[WIDTH-2:0], rotate ? data_out[WIDTH-1] : ser_in_l}; ser_out <= old data_out[WIDTH-1].
  - Right: data_out <= {rotate ? data_out[0] : (arith ? data_out[WIDTH-1] : ser_in_r), data_out[WIDTH-1:1]}; ser_out <= old data_out[0].
- FSM states: IDLE, RUN, DONE.
- IDLE/DONE command priority, sampled each edge:
  1. load: data_out <= data_in; ser_out unchanged.
  2. start with shift_left or shift_right:
     - latch direction (left wins if both) and count.
     - count=0: go to DONE, no data change.
     - otherwise: perform the first step this edge; if count=1 go to DONE, else go to RUN with remaining = count-1.
  3. start with neither direction: ignored.
  4. shift_left (no start): one left step.
  5. shift_right (no start): one right step.
  6. Otherwise: hold.
- RUN:
  - One step per edge in the latched direction.
  - rotate, arith, ser_in_l and ser_in_r are sampled live each step.
  - remaining decrements; the step with remaining=1 moves to DONE.
  - start, shift_left and shift_right are ignored.
  - load aborts: data_out <= data_in, go to IDLE, done is not pulsed.
- DONE:
  - Lasts exactly one cycle, then IDLE unless a new command is accepted.
  - A command accepted in DONE behaves as in IDLE.
- Outputs:
  - busy=1 only in RUN, and in the cycle after an accepted start with count>1.
  - done=1 only in the DONE state.
- Latency:
  - start with count=N (N>=1) gives the final data after N edges; done is high for the cycle following the Nth edge.
  - busy is high for N-1 cycles.

Optional Feature:
USR_PARITY_EN
- Defined: adds output port parity (1 bit), registered, equal to the XOR-reduction of the data_out value being written on the same edge. Reset value 0.
- Not defined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset and load (WIDTH=8): reset=1 with data_in=8'hB5 -> data_out=00, ser_out=0, busy=0, done=0. Release reset, pulse load -> data_out=B5 next edge. Then load and shift_left in the same cycle with data_in=3C -> data_out=3C (load wins).
- Single steps from B5:
  - shift_left, ser_in_l=1 -> 6B, ser_out=1.
  - Reload B5; shift_right, arith=0, ser_in_r=0 -> 5A, ser_out=1.
  - Reload B5; shift_right, arith=1 -> DA.
- Multi-step rotate: load 81, start+shift_left, rotate=1, count=3 -> data 03, 06, 0C on successive edges. busy high 2 cycles. done high exactly one cycle after the third edge. Final data_out=0C.
- Zero count: start+shift_right, count=0 on 0C -> done pulses next cycle, data_out stays 0C, busy never asserts.
- Abort and mid-op reset:
  - start left, count=5 on 01; assert load with data_in=A5 during RUN -> data_out=A5, busy=0, done never pulses.
  - Repeat, assert reset mid-RUN -> all outputs 0 immediately.
- USR_PARITY_EN build: load 07 -> parity=1; shift_left, ser_in_l=0 -> 0E, parity=1; load 03 -> parity=0.
